// File: rtl/ndarray_setitem_regfile_pkg.sv
// ---------------------------------------------------------------------------
// ndarray_setitem_regfile_pkg
//   Shared geometry and types for the runtime-indexed (setitem) ndarray
//   register file: BANKS x DEPTH x WIDTH elements of ELEM bits each.
//   Packed ordering follows the ndarray flattening: element [b][r][e] sits
//   at flat bits ((b*DEPTH+r)*WIDTH+e)*ELEM +: ELEM.
// ---------------------------------------------------------------------------
package ndarray_setitem_regfile_pkg;

  localparam int BANKS = 2;   // outermost dimension, one write/read port each
  localparam int DEPTH = 4;   // rows per bank
  localparam int WIDTH = 3;   // elements per row
  localparam int ELEM  = 2;   // bits per element

  // Row index width; kept at least 1 so a single-row bank still has a port.
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef logic [ELEM-1:0]  elem_t;
  typedef elem_t [WIDTH-1:0] row_t;
  typedef row_t  [DEPTH-1:0] bank_t;

endpackage

// File: rtl/ndarray_setitem_bank.sv
// ---------------------------------------------------------------------------
// ndarray_setitem_bank
//   One bank of the register array: DEPTH rows of row_t, a masked row write
//   at a runtime index, and a registered write-first read port.
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-high reset
//   wen      in   write enable
//   waddr    in   row index for the write
//   wdata    in   row data; element e is written where wmask[e] = 1
//   wmask    in   per-element write mask
//   raddr    in   row index for the read
//   rdata    out  registered read data (0 for out-of-range rows)
//   accepted out  this cycle's write is in range and will land at the edge
// ---------------------------------------------------------------------------
module ndarray_setitem_bank
  import ndarray_setitem_regfile_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             wen,
  input  logic [AW-1:0]    waddr,
  input  row_t             wdata,
  input  logic [WIDTH-1:0] wmask,
  input  logic [AW-1:0]    raddr,
  output row_t             rdata,
  output logic             accepted
);

  bank_t mem;
  row_t  merged;
  row_t  rd_row;
  logic  w_ok;
  logic  r_ok;

  // Range checks only exist when DEPTH leaves unused index codes.
  if ((1 << AW) == DEPTH) begin : g_full_range
    assign w_ok = 1'b1;
    assign r_ok = 1'b1;
  end else begin : g_part_range
    assign w_ok = (int'(waddr) < DEPTH);
    assign r_ok = (int'(raddr) < DEPTH);
  end

  assign accepted = wen & w_ok;

  // Current row with the masked elements replaced; a zero mask yields the
  // unchanged row, so the write still "happens" for dirty tracking.
  always_comb begin
    // NOTE: default first so every path assigns merged and no latch is inferred.
    merged = mem[waddr];
    for (int e = 0; e < WIDTH; e++) begin
      if (wmask[e]) merged[e] = wdata[e];
    end
  end

  // Write-first: a read of the row being written sees the merged new row.
  always_comb begin
    rd_row = '0;
    if (r_ok) begin
      if (accepted && (raddr == waddr)) rd_row = merged;
      else                              rd_row = mem[raddr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the array is register-built and must read 0 after reset, so it
      // is reset like any other flop rather than left to a RAM macro.
      mem   <= '0;
      rdata <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values.
      if (accepted) mem[waddr] <= merged;
      rdata <= rd_row;
    end
  end

endmodule

// File: rtl/ndarray_setitem_regfile.sv
// ---------------------------------------------------------------------------
// ndarray_setitem_regfile
//   BANKS x DEPTH x WIDTH register array with one masked, runtime-indexed
//   row write port and one registered write-first read port per bank, plus
//   per-row dirty bits.
//
// Ports
//   CLK        in   rising-edge clock
//   ASYNCRESET in   asynchronous active-high reset
//   wen        in   [BANKS]               write enable per bank
//   waddr      in   [BANKS][AW]           write row index per bank
//   wdata      in   [BANKS] row_t         write row data per bank
//   wmask      in   [BANKS][WIDTH]        per-element write mask per bank
//   raddr      in   [BANKS][AW]           read row index per bank
//   rdata      out  [BANKS] row_t         registered read data per bank
//   dirty      out  [BANKS*DEPTH]         row dirty bits, bit b*DEPTH+r
//   clr_dirty  in   synchronous clear of all dirty bits (a same-edge write
//                   still leaves its own row's bit set)
// ---------------------------------------------------------------------------
module ndarray_setitem_regfile
  import ndarray_setitem_regfile_pkg::*;
(
  input  logic                        CLK,
  input  logic                        ASYNCRESET,
  input  logic [BANKS-1:0]            wen,
  input  logic [BANKS-1:0][AW-1:0]    waddr,
  input  row_t [BANKS-1:0]            wdata,
  input  logic [BANKS-1:0][WIDTH-1:0] wmask,
  input  logic [BANKS-1:0][AW-1:0]    raddr,
  output row_t [BANKS-1:0]            rdata,
  output logic [BANKS*DEPTH-1:0]      dirty,
  input  logic                        clr_dirty
);

  logic [BANKS-1:0]            accepted;
  logic [BANKS-1:0][DEPTH-1:0] set_vec;
  logic [BANKS-1:0][DEPTH-1:0] dirty_q;

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    ndarray_setitem_bank u_bank (
      .clk      (CLK),
      .rst      (ASYNCRESET),
      .wen      (wen[b]),
      .waddr    (waddr[b]),
      .wdata    (wdata[b]),
      .wmask    (wmask[b]),
      .raddr    (raddr[b]),
      .rdata    (rdata[b]),
      .accepted (accepted[b])
    );

    // One-hot row select for this bank's accepted write.
    assign set_vec[b] = accepted[b] ? (DEPTH'(1) << waddr[b]) : '0;
  end

  // Set wins over clear: the clear drops history, this edge's writes remain.
  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET)     dirty_q <= '0;
    else if (clr_dirty) dirty_q <= set_vec;
    else                dirty_q <= dirty_q | set_vec;
  end

  // Packed [bank][row] flattens to bit b*DEPTH+r.
  assign dirty = dirty_q;

endmodule

// File: tb/tb_ndarray_setitem_regfile.sv
// ---------------------------------------------------------------------------
// tb_ndarray_setitem_regfile
//   Directed, self-checking bench for ndarray_setitem_regfile. Inputs change
//   1 ns after a rising edge; outputs are sampled at the same point.
// ---------------------------------------------------------------------------
module tb_ndarray_setitem_regfile;
  import ndarray_setitem_regfile_pkg::*;

  logic                        CLK;
  logic                        ASYNCRESET;
  logic [BANKS-1:0]            wen;
  logic [BANKS-1:0][AW-1:0]    waddr;
  row_t [BANKS-1:0]            wdata;
  logic [BANKS-1:0][WIDTH-1:0] wmask;
  logic [BANKS-1:0][AW-1:0]    raddr;
  row_t [BANKS-1:0]            rdata;
  logic [BANKS*DEPTH-1:0]      dirty;
  logic                        clr_dirty;

  int vectors     = 0;
  int miscompares = 0;

  ndarray_setitem_regfile dut (
    .CLK        (CLK),
    .ASYNCRESET (ASYNCRESET),
    .wen        (wen),
    .waddr      (waddr),
    .wdata      (wdata),
    .wmask      (wmask),
    .raddr      (raddr),
    .rdata      (rdata),
    .dirty      (dirty),
    .clr_dirty  (clr_dirty)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [15:0] observed,
                       input logic [15:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    ASYNCRESET = 1'b1;
    wen        = '0;
    waddr      = '0;
    wdata      = '0;
    wmask      = '0;
    raddr      = '0;
    clr_dirty  = 1'b0;
    raddr[0]   = 2'd2;

    // Reset state.
    repeat (2) @(posedge CLK);
    #1;
    check("rst_rdata0", 16'(rdata[0]), 16'h0);
    check("rst_dirty",  16'(dirty),    16'h0);
    @(negedge CLK);
    ASYNCRESET = 1'b0;

    // Idle after release: nothing written, nothing dirty.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_rdata0", 16'(rdata[0]), 16'h0);
      check("idle_dirty",  16'(dirty),    16'h0);
    end

    // Full-row write bank 0 row 1 = {3,2,1}.
    wen[0] = 1'b1; waddr[0] = 2'd1; wdata[0] = 6'b11_10_01; wmask[0] = 3'b111;
    tick();
    check("wr_dirty", 16'(dirty), 16'h02);
    wen[0] = 1'b0; raddr[0] = 2'd1;
    tick();
    check("wr_read_b0r1", 16'(rdata[0]), 16'h39);

    // Masked write of element 1 only, with same-edge read of that row.
    wen[0] = 1'b1; waddr[0] = 2'd1; wdata[0] = 6'b00_00_00; wmask[0] = 3'b010;
    raddr[1] = 2'd1;
    tick();
    check("mask_bypass_b0r1", 16'(rdata[0]), 16'h31);
    check("mask_b1r1_untouched", 16'(rdata[1]), 16'h00);
    wen[0] = 1'b0;
    tick();
    check("mask_stored_b0r1", 16'(rdata[0]), 16'h31);

    // Same-edge write and read on bank 1 row 3 goes through the bypass.
    wen[1] = 1'b1; waddr[1] = 2'd3; wdata[1] = 6'b01_01_01; wmask[1] = 3'b111;
    raddr[1] = 2'd3;
    tick();
    check("bypass_b1r3", 16'(rdata[1]), 16'h15);
    check("bypass_dirty", 16'(dirty), 16'h82);

    // Zero-mask writes to every other row: dirty fills, storage unchanged.
    wdata[0] = 6'h3f; wdata[1] = 6'h3f; wmask[0] = 3'b000; wmask[1] = 3'b000;
    wen = 2'b11;
    waddr[0] = 2'd0; waddr[1] = 2'd0; tick();
    waddr[0] = 2'd2; waddr[1] = 2'd1; tick();
    waddr[0] = 2'd3; waddr[1] = 2'd2; tick();
    check("fill_dirty", 16'(dirty), 16'hFF);
    check("nomask_b1r3", 16'(rdata[1]), 16'h15);
    wen[1] = 1'b0;
    waddr[0] = 2'd1; raddr[0] = 2'd1;
    tick();
    check("nomask_b0r1", 16'(rdata[0]), 16'h31);

    // Clear together with a masked write to bank 1 row 0: set wins there.
    wen[0] = 1'b0;
    wen[1] = 1'b1; waddr[1] = 2'd0; wdata[1] = 6'b10_11_01; wmask[1] = 3'b101;
    raddr[1] = 2'd0; clr_dirty = 1'b1;
    tick();
    check("clr_set_dirty", 16'(dirty), 16'h10);
    check("clr_set_b1r0", 16'(rdata[1]), 16'h21);
    wen[1] = 1'b0;
    tick();
    check("clr_only_dirty", 16'(dirty), 16'h00);
    clr_dirty = 1'b0;

    // Asynchronous reset in mid-cycle, no clock edge involved.
    tick();
    check("pre_rst_b0", 16'(rdata[0]), 16'h31);
    check("pre_rst_b1", 16'(rdata[1]), 16'h21);
    wen[0] = 1'b1; waddr[0] = 2'd3; wdata[0] = 6'h2a; wmask[0] = 3'b111;
    tick();
    check("pre_rst_dirty", 16'(dirty), 16'h08);
    #2;
    ASYNCRESET = 1'b1;
    #1;
    check("async_rdata0", 16'(rdata[0]), 16'h0);
    check("async_rdata1", 16'(rdata[1]), 16'h0);
    check("async_dirty",  16'(dirty),    16'h0);

    // A write presented while reset is held is dropped.
    wen[0] = 1'b1; waddr[0] = 2'd2; wdata[0] = 6'h3f; wmask[0] = 3'b111;
    raddr[0] = 2'd2; clr_dirty = 1'b1;
    tick();
    check("held_rst_rdata0", 16'(rdata[0]), 16'h0);
    check("held_rst_dirty",  16'(dirty),    16'h0);
    wen = '0; clr_dirty = 1'b0;
    @(negedge CLK);
    ASYNCRESET = 1'b0;

    // Every row of both banks reads back as 0.
    for (int r = 0; r < DEPTH; r++) begin
      raddr[0] = AW'(r); raddr[1] = AW'(r);
      tick();
      check("post_rst_b0", 16'(rdata[0]), 16'h0);
      check("post_rst_b1", 16'(rdata[1]), 16'h0);
    end
    check("post_rst_dirty", 16'(dirty), 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
